// File: rtl/bluetooth_transmit.sv
// UART 8N1 transmitter feeding the Bluetooth module's RX pin, with a small
// byte FIFO so the control logic can queue status/ack bytes without stalling.
module bluetooth_transmit #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       inclk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Tx,
    output logic       busy,
    output logic       fifo_empty
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_ZERO  = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_head_s;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] baud_cnt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             tx_r;
    logic             tx_s;
    logic             busy_r;
    logic             baud_last_s;

    assign tx_ready     = (count_r != COUNT_FULL);
    assign fifo_empty_s = (count_r == COUNT_ZERO);
    assign fifo_empty   = fifo_empty_s;
    assign push_s       = tx_valid && tx_ready;
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r];
    assign baud_last_s  = (baud_cnt_r == BAUD_LAST);
    assign Tx           = tx_r;
    assign busy         = busy_r;

    // FIFO storage: data only, the pointers define which entries are live
    always_ff @(posedge inclk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer: next state, baud counter, bit index, shifter and FIFO pop
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_cnt_s = BAUD_ZERO;
                bit_idx_s  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_head_s;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    bit_idx_s  = 3'd0;
                    state_s    = ST_DATA;
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    shift_s    = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_s = 3'd0;
                        state_s   = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    // Chain straight into the next frame when more bytes are queued
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_head_s;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            default: begin
                baud_cnt_s = BAUD_ZERO;
                bit_idx_s  = 3'd0;
                state_s    = ST_IDLE;
            end
        endcase
    end

    // Line level for the current state; registered below so Tx is glitch-free
    always_comb begin
        tx_s = 1'b1;
        case (state_r)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_r[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

    // Sequencer state plus registered line and busy, both aligned to the frame on the wire
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            busy_r     <= (state_r != ST_IDLE);
        end
    end

endmodule
